// File: rtl/qdec_pkg.sv
// -----------------------------------------------------------------------------
// qdec_pkg
// Shared definitions for the quadrature step decoder: FSM state encoding,
// the four quadrature phase codes {A,B}, and the forward phase successor
// function used by the decoder and its testbench.
// -----------------------------------------------------------------------------
package qdec_pkg;

    // Decoder FSM: INIT settles the filters, RUN decodes steps.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } qdec_state_e;

    // Phase codes, listed in forward (up) rotation order.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    // Phase that follows ph when the encoder turns one step in the up direction.
    function automatic logic [1:0] next_phase_up(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            PH_10:   nxt = PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage : qdec_pkg

// File: rtl/quad_step_decoder_if.sv
// -----------------------------------------------------------------------------
// quad_step_decoder_if
// Groups the decoder's control, raw encoder inputs and step/status outputs.
//   enable        : gate for up/down/err pulses
//   qa, qb        : raw asynchronous encoder channels
//   up, down, err : one-cycle step / illegal-jump pulses
//   phase         : filtered phase {A,B}
//   ready         : high once the start-up settling period is over
// master = the side that drives enable/qa/qb (encoder + controller);
// slave  = the decoder itself.
// -----------------------------------------------------------------------------
interface quad_step_decoder_if;
    logic       enable;
    logic       qa;
    logic       qb;
    logic       up;
    logic       down;
    logic       err;
    logic [1:0] phase;
    logic       ready;

    modport master (
        output enable, qa, qb,
        input  up, down, err, phase, ready
    );

    modport slave (
        input  enable, qa, qb,
        output up, down, err, phase, ready
    );
endinterface : quad_step_decoder_if

// File: rtl/qdec_chan_filter.sv
// -----------------------------------------------------------------------------
// qdec_chan_filter
// One encoder channel: two-flop synchronizer followed by a persistence filter.
// The filtered bit only follows the synchronized input after the two have
// disagreed for FILTER_CYCLES consecutive clocks; any shorter excursion is
// discarded. While bypass is high the filter tracks the synchronizer directly.
//   clk    : system clock
//   rstn   : asynchronous active-low reset
//   bypass : load filt straight from the synchronizer (start-up settling)
//   raw    : asynchronous channel input
//   filt   : filtered, glitch-free channel value
// -----------------------------------------------------------------------------
module qdec_chan_filter #(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic bypass,
    input  logic raw,
    output logic filt
);

    // Mismatch count at which the new value is accepted on the same edge.
    localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

    logic       s1_r;
    logic       s2_r;
    logic       filt_r;
    logic [3:0] cnt_r;

    // Synchronizer chain plus mismatch counter; counter never exceeds CNT_LAST.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            filt_r <= 1'b0;
            cnt_r  <= 4'd0;
        end else begin
            s1_r <= raw;
            s2_r <= s1_r;
            if (bypass) begin
                filt_r <= s2_r;
                cnt_r  <= 4'd0;
            end else if (s2_r == filt_r) begin
                cnt_r <= 4'd0;
            end else if (cnt_r >= CNT_LAST) begin
                // FILTER_CYCLES-th consecutive mismatch: accept the new value.
                filt_r <= s2_r;
                cnt_r  <= 4'd0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    assign filt = filt_r;

endmodule : qdec_chan_filter

// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
// Turns a bouncing two-channel quadrature input into registered one-cycle
// up/down step pulses for a downstream up/down counter, and flags illegal
// two-bit phase jumps.
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : slave side of quad_step_decoder_if
//          (enable, qa, qb in; up, down, err, phase, ready out)
// STEP_DIV = 1 emits a step per phase edge; STEP_DIV = 4 emits a step only
// when the phase returns to 00 (one per full quadrature cycle).
// -----------------------------------------------------------------------------
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned STEP_DIV      = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    quad_step_decoder_if.slave   bus
);

    // INIT lasts FILTER_CYCLES+3 clocks: settle counter 0 .. FILTER_CYCLES+2.
    localparam logic [4:0] SETTLE_LAST = 5'(FILTER_CYCLES + 2);
    localparam bit         DIV4        = (STEP_DIV == 4);

    qdec_state_e state_r;
    logic [4:0]  settle_r;
    logic        ready_r;
    logic [1:0]  prev_r;
    logic        up_r;
    logic        down_r;
    logic        err_r;

    logic        bypass_s;
    logic        fa_s;
    logic        fb_s;
    logic [1:0]  cur_s;
    logic [1:0]  delta_s;
    logic        fwd_s;
    logic        up_s;
    logic        down_s;
    logic        err_s;

    assign bypass_s = (state_r == ST_INIT);

    qdec_chan_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk    (clk),
        .rstn   (rstn),
        .bypass (bypass_s),
        .raw    (bus.qa),
        .filt   (fa_s)
    );

    qdec_chan_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk    (clk),
        .rstn   (rstn),
        .bypass (bypass_s),
        .raw    (bus.qb),
        .filt   (fb_s)
    );

    assign cur_s   = {fa_s, fb_s};
    assign delta_s = prev_r ^ cur_s;
    // A single-bit change is either the forward successor or the reverse one.
    assign fwd_s   = (cur_s == next_phase_up(prev_r));

    // Step/error decode of the previous-to-current phase transition.
    always_comb begin
        up_s   = 1'b0;
        down_s = 1'b0;
        err_s  = 1'b0;
        if ((state_r == ST_RUN) && bus.enable) begin
            case (delta_s)
                2'b00: begin
                    up_s = 1'b0;
                end
                2'b11: begin
                    err_s = 1'b1;
                end
                default: begin
                    if (DIV4) begin
                        // Only the return to 00 counts; direction from where it came.
                        up_s   = fwd_s  && (cur_s == PH_00);
                        down_s = !fwd_s && (cur_s == PH_00);
                    end else begin
                        up_s   = fwd_s;
                        down_s = !fwd_s;
                    end
                end
            endcase
        end else begin
            // INIT or disabled: prev keeps tracking, nothing is emitted.
            up_s = 1'b0;
        end
    end

    // FSM, settle counter, phase history and registered pulse outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_INIT;
            settle_r <= 5'd0;
            ready_r  <= 1'b0;
            prev_r   <= PH_00;
            up_r     <= 1'b0;
            down_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            prev_r <= cur_s;
            up_r   <= up_s;
            down_r <= down_s;
            err_r  <= err_s;
            case (state_r)
                ST_INIT: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        settle_r <= settle_r + 5'd1;
                    end
                end
                ST_RUN: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_INIT;
                    settle_r <= 5'd0;
                    ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.up    = up_r;
    assign bus.down  = down_r;
    assign bus.err   = err_r;
    assign bus.phase = cur_s;
    assign bus.ready = ready_r;

endmodule : quad_step_decoder

// File: tb/tb_quad_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_step_decoder
// Two decoders (STEP_DIV=1 and STEP_DIV=4) share one stimulus stream. Each
// directed step pushes its hand-computed expected pulse (kind, phase, cycle)
// into a per-DUT queue; monitors pop and compare whenever a pulse appears.
// -----------------------------------------------------------------------------
module tb_quad_step_decoder;
    import qdec_pkg::*;

    localparam int FC  = 4;
    localparam int LAT = FC + 3;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_UP   = 2'd1;
    localparam logic [1:0] K_DN   = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [1:0] ph;
        int         due;
    } exp_t;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic enable = 1'b1;
    logic qa     = 1'b1;
    logic qb     = 1'b1;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    exp_t q1[$];
    exp_t q4[$];

    // downstream 4-bit counter model fed by the STEP_DIV=1 decoder
    bit         count_on = 1'b0;
    logic [3:0] ctr      = 4'd0;
    int         carries  = 0;
    int         n_up1    = 0;
    int         n_up4    = 0;

    quad_step_decoder_if bus1();
    quad_step_decoder_if bus4();

    assign bus1.enable = enable;
    assign bus1.qa     = qa;
    assign bus1.qb     = qb;
    assign bus4.enable = enable;
    assign bus4.qa     = qa;
    assign bus4.qb     = qb;

    quad_step_decoder #(.FILTER_CYCLES(FC), .STEP_DIV(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    quad_step_decoder #(.FILTER_CYCLES(FC), .STEP_DIV(4)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (count_on) begin
            if (bus1.up) begin
                if (ctr == 4'd15) carries = carries + 1;
                ctr   <= ctr + 4'd1;
                n_up1 = n_up1 + 1;
            end
            if (bus4.up) n_up4 = n_up4 + 1;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic judge(input string nm, input logic u, input logic d, input logic e,
                         input logic [1:0] ph, input bit has, input exp_t ex);
        logic [1:0] k;
        k = u ? K_UP : (d ? K_DN : K_ERR);
        n_cmp++;
        if (!has) begin
            n_bad++;
            $display("FAIL %s_unexpected: got up=%b down=%b err=%b phase=%b at cycle %0d, expected no pulse",
                     nm, u, d, e, ph, cyc);
        end else if (({1'b0, u} + {1'b0, d} + {1'b0, e}) > 2'd1) begin
            n_bad++;
            $display("FAIL %s_exclusive: got up=%b down=%b err=%b, expected one-hot", nm, u, d, e);
        end else if (k != ex.kind || ph != ex.ph || cyc != ex.due) begin
            n_bad++;
            $display("FAIL %s_pulse: got kind=%0d phase=%b cycle=%0d expected kind=%0d phase=%b cycle=%0d",
                     nm, k, ph, cyc, ex.kind, ex.ph, ex.due);
        end
    endtask

    // monitor for the STEP_DIV=1 decoder
    always @(negedge clk) begin
        exp_t dummy;
        dummy = '{K_NONE, 2'b00, 0};
        if (rstn) begin
            if (bus1.up || bus1.down || bus1.err) begin
                if (q1.size() == 0) judge("d1", bus1.up, bus1.down, bus1.err, bus1.phase, 1'b0, dummy);
                else                judge("d1", bus1.up, bus1.down, bus1.err, bus1.phase, 1'b1, q1.pop_front());
            end else if (q1.size() != 0 && q1[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d1_missing: got nothing by cycle %0d, expected kind=%0d at cycle %0d",
                         cyc, q1[0].kind, q1[0].due);
                void'(q1.pop_front());
            end
        end
    end

    // monitor for the STEP_DIV=4 decoder
    always @(negedge clk) begin
        exp_t dummy;
        dummy = '{K_NONE, 2'b00, 0};
        if (rstn) begin
            if (bus4.up || bus4.down || bus4.err) begin
                if (q4.size() == 0) judge("d4", bus4.up, bus4.down, bus4.err, bus4.phase, 1'b0, dummy);
                else                judge("d4", bus4.up, bus4.down, bus4.err, bus4.phase, 1'b1, q4.pop_front());
            end else if (q4.size() != 0 && q4[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d4_missing: got nothing by cycle %0d, expected kind=%0d at cycle %0d",
                         cyc, q4[0].kind, q4[0].due);
                void'(q4.pop_front());
            end
        end
    end

    // drive a new phase, queue the expected pulse per decoder, then idle 10 cycles
    task automatic step(input logic a, input logic b, input logic [1:0] k1, input logic [1:0] k4);
        @(negedge clk);
        if (k1 != K_NONE) q1.push_back('{k1, {a, b}, cyc + LAT});
        if (k4 != K_NONE) q4.push_back('{k4, {a, b}, cyc + LAT});
        qa = a;
        qb = b;
        repeat (9) @(negedge clk);
    endtask

    task automatic chk_outs(input string nm, input logic [1:0] ph, input logic rdy);
        chk({nm, "_pulses1"}, {5'd0, bus1.up, bus1.down, bus1.err}, 8'd0);
        chk({nm, "_pulses4"}, {5'd0, bus4.up, bus4.down, bus4.err}, 8'd0);
        chk({nm, "_phase1"},  {6'd0, bus1.phase}, {6'd0, ph});
        chk({nm, "_phase4"},  {6'd0, bus4.phase}, {6'd0, ph});
        chk({nm, "_ready1"},  {7'd0, bus1.ready}, {7'd0, rdy});
        chk({nm, "_ready4"},  {7'd0, bus4.ready}, {7'd0, rdy});
    endtask

    initial begin
        logic [1:0] ph;
        int         c;

        // 1: reset, then INIT with 11 held
        repeat (3) @(negedge clk);
        chk_outs("reset", 2'b00, 1'b0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("init_ready_early", {7'd0, bus1.ready}, 8'd0);
        @(negedge clk);
        chk_outs("init_done", 2'b11, 1'b1);

        // walk 11 -> 10 -> 00
        step(1'b1, 1'b0, K_UP, K_NONE);
        step(1'b0, 1'b0, K_UP, K_UP);

        // 2: 00 -> 01 up, 01 -> 00 down
        step(1'b0, 1'b1, K_UP, K_NONE);
        chk("t2_phase01", {6'd0, bus1.phase}, 8'h01);
        step(1'b0, 1'b0, K_DN, K_DN);
        chk("t2_phase00", {6'd0, bus1.phase}, 8'h00);

        // 3: 16 forward edges
        count_on = 1'b1;
        ph = PH_00;
        for (int i = 0; i < 16; i++) begin
            ph = next_phase_up(ph);
            step(ph[1], ph[0], K_UP, (ph == PH_00) ? K_UP : K_NONE);
        end
        count_on = 1'b0;
        chk("t3_ctr",     {4'd0, ctr}, 8'd0);
        chk("t3_carries", 8'(carries), 8'd1);
        chk("t3_ups1",    8'(n_up1), 8'd16);
        chk("t3_ups4",    8'(n_up4), 8'd4);

        // 4: 3-cycle glitch rejected, 4-cycle pulse accepted and then reverted
        @(negedge clk);
        qa = 1'b1;
        repeat (3) @(negedge clk);
        qa = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_glitch_phase", {6'd0, bus1.phase}, 8'h00);
        c = cyc;
        q1.push_back('{K_DN, 2'b10, c + LAT});
        q1.push_back('{K_UP, 2'b00, c + LAT + 4});
        q4.push_back('{K_UP, 2'b00, c + LAT + 4});
        qa = 1'b1;
        repeat (4) @(negedge clk);
        qa = 1'b0;
        repeat (14) @(negedge clk);

        // 5: illegal 00 -> 11, then 11 -> 10 up, back to 00
        step(1'b1, 1'b1, K_ERR, K_ERR);
        chk("t5_phase11", {6'd0, bus4.phase}, 8'h03);
        step(1'b1, 1'b0, K_UP, K_NONE);
        step(1'b0, 1'b0, K_UP, K_UP);

        // 6: steps while disabled, then re-enable with no stale pulses
        @(negedge clk);
        enable = 1'b0;
        step(1'b0, 1'b1, K_NONE, K_NONE);
        step(1'b1, 1'b1, K_NONE, K_NONE);
        step(1'b1, 1'b0, K_NONE, K_NONE);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_phase10", {6'd0, bus1.phase}, 8'h02);

        // reset while the filter is mid-count
        qa = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_outs("midrst", 2'b00, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk_outs("rerun", 2'b00, 1'b1);

        chk("q1_drained", 8'(q1.size()), 8'd0);
        chk("q4_drained", 8'(q4.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_quad_step_decoder
